// File: rtl/bomberman_lives.sv
// Per-player life counters, post-hit invulnerability and winner latch for two players.
// Optional sprite blink strobes are built only when LIVES_BLINK_EN is defined.
module bomberman_lives #(
    parameter int START_LIVES    = 3,
    parameter int COOLDOWN_TICKS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       player_reset,
    input  logic       refresh,
    input  logic       p1_hit,
    input  logic       p2_hit,
    output logic [1:0] p1_lives,
    output logic [1:0] p2_lives,
    output logic       p1_invuln,
    output logic       p2_invuln,
    output logic       p1_blink,
    output logic       p2_blink,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
    localparam logic [3:0] CD_INIT    = 4'(COOLDOWN_TICKS - 1);

    logic            refresh_q_reg;
    logic            tick;
    logic            step;
    logic            frozen;
    logic [1:0]      winner_reg;
    logic [1:0]      hit_vec;
    logic [1:0]      take_hit;
    logic [1:0]      dies;
    logic [1:0]      invuln_vec;
    logic [1:0]      blink_vec;
    logic [1:0][1:0] lives_vec;

    // refresh_q powers up high so a refresh already high at reset release is not a tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset) refresh_q_reg <= 1'b1;
        else       refresh_q_reg <= refresh;
    end

    assign tick    = refresh && !refresh_q_reg;
    assign step    = tick && !player_reset;
    assign frozen  = (winner_reg != 2'd0);
    assign hit_vec = {p2_hit, p1_hit};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_player
            state_t     state_reg;
            logic [1:0] lives_reg;
            logic [3:0] cd_reg;
            logic       invuln_reg;
            logic       vulnerable;

            // The tick that ends the cooldown already counts as a vulnerable tick
            assign vulnerable   = (state_reg == ALIVE) ||
                                  (state_reg == INVULN && cd_reg == 4'd0);
            assign take_hit[gi] = step && !frozen && vulnerable && hit_vec[gi] &&
                                  (lives_reg != 2'd0);
            assign dies[gi]     = take_hit[gi] && (lives_reg == 2'd1);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    state_reg  <= ALIVE;
                    lives_reg  <= LIVES_INIT;
                    cd_reg     <= 4'd0;
                    invuln_reg <= 1'b0;
                end else if (player_reset) begin
                    state_reg  <= ALIVE;
                    lives_reg  <= LIVES_INIT;
                    cd_reg     <= 4'd0;
                    invuln_reg <= 1'b0;
                end else if (take_hit[gi]) begin
                    lives_reg <= lives_reg - 2'd1;
                    if (dies[gi]) begin
                        state_reg  <= DEAD;
                        cd_reg     <= 4'd0;
                        invuln_reg <= 1'b0;
                    end else begin
                        state_reg  <= INVULN;
                        cd_reg     <= CD_INIT;
                        invuln_reg <= 1'b1;
                    end
                end else if (step && state_reg == INVULN) begin
                    if (cd_reg == 4'd0) begin
                        state_reg  <= ALIVE;
                        invuln_reg <= 1'b0;
                    end else begin
                        cd_reg <= cd_reg - 4'd1;
                    end
                end
            end

            assign lives_vec[gi]  = lives_reg;
            assign invuln_vec[gi] = invuln_reg;

`ifdef LIVES_BLINK_EN
            logic blink_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    blink_reg <= 1'b0;
                end else if (player_reset || take_hit[gi]) begin
                    blink_reg <= 1'b0;
                end else if (step && state_reg == INVULN) begin
                    blink_reg <= (cd_reg == 4'd0) ? 1'b0 : ~blink_reg;
                end
            end

            assign blink_vec[gi] = blink_reg;
`else
            assign blink_vec[gi] = 1'b0;
`endif
        end
    endgenerate

    // Bit 1 flags a P1 death, bit 0 a P2 death: 1 = P1 wins, 2 = P2 wins, 3 = draw
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            winner_reg <= 2'd0;
        end else if (player_reset) begin
            winner_reg <= 2'd0;
        end else if (dies != 2'b00) begin
            winner_reg <= {dies[0], dies[1]};
        end
    end

    assign p1_lives  = lives_vec[0];
    assign p2_lives  = lives_vec[1];
    assign p1_invuln = invuln_vec[0];
    assign p2_invuln = invuln_vec[1];
    assign p1_blink  = blink_vec[0];
    assign p2_blink  = blink_vec[1];
    assign winner    = winner_reg;

endmodule

// File: tb/tb_bomberman_lives.sv
// Bench for bomberman_lives: constant-table scenarios, hand-written reset/blink corners,
// and random frames checked against a tick-count based model.
module tb_bomberman_lives;

    localparam int START = 3;
    localparam int CD    = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       player_reset = 1'b0;
    logic       refresh = 1'b1;
    logic       p1_hit = 1'b0;
    logic       p2_hit = 1'b0;
    logic [1:0] p1_lives, p2_lives, winner;
    logic       p1_invuln, p2_invuln, p1_blink, p2_blink;

    int total = 0;
    int bad   = 0;

    bomberman_lives #(.START_LIVES(START), .COOLDOWN_TICKS(CD)) dut (
        .clock(clock), .reset(reset), .player_reset(player_reset), .refresh(refresh),
        .p1_hit(p1_hit), .p2_hit(p2_hit),
        .p1_lives(p1_lives), .p2_lives(p2_lives),
        .p1_invuln(p1_invuln), .p2_invuln(p2_invuln),
        .p1_blink(p1_blink), .p2_blink(p2_blink),
        .winner(winner)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference model: a player is vulnerable once the tick count reaches m_vuln
    int m_lives[2];
    int m_vuln[2];
    int m_hitt[2];
    int m_win;
    int m_t = 0;

    function automatic void model_init();
        for (int p = 0; p < 2; p++) begin
            m_lives[p] = START;
            m_vuln[p]  = 0;
            m_hitt[p]  = 0;
        end
        m_win = 0;
    endfunction

    function automatic void model_tick(input logic h1, input logic h2);
        bit   d[2];
        logic h[2];
        bit   fr;
        h[0] = h1;
        h[1] = h2;
        fr   = (m_win != 0);
        m_t++;
        for (int p = 0; p < 2; p++) begin
            d[p] = 0;
            if (!fr && h[p] && m_lives[p] > 0 && m_t >= m_vuln[p]) begin
                m_lives[p]--;
                m_vuln[p] = m_t + CD;
                m_hitt[p] = m_t;
                d[p] = (m_lives[p] == 0);
            end
        end
        if (d[0] && d[1]) m_win = 3;
        else if (d[1])    m_win = 1;
        else if (d[0])    m_win = 2;
    endfunction

    function automatic int exp_inv(input int p);
        return (m_lives[p] > 0 && m_t < m_vuln[p]) ? 1 : 0;
    endfunction

    function automatic int exp_blink(input int p);
`ifdef LIVES_BLINK_EN
        return (exp_inv(p) != 0) ? ((m_t - m_hitt[p]) % 2) : 0;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " p1_lives"},  int'(p1_lives),  m_lives[0]);
        chk({tag, " p2_lives"},  int'(p2_lives),  m_lives[1]);
        chk({tag, " p1_invuln"}, int'(p1_invuln), exp_inv(0));
        chk({tag, " p2_invuln"}, int'(p2_invuln), exp_inv(1));
        chk({tag, " p1_blink"},  int'(p1_blink),  exp_blink(0));
        chk({tag, " p2_blink"},  int'(p2_blink),  exp_blink(1));
        chk({tag, " winner"},    int'(winner),    m_win);
    endtask

    // Raise refresh with the given hits/player_reset; returns one clock after the tick edge
    task automatic run_tick(input logic h1, input logic h2, input logic pr);
        @(negedge clock);
        p1_hit = h1;
        p2_hit = h2;
        player_reset = pr;
        refresh = 1'b1;
        @(negedge clock);
        player_reset = 1'b0;
        if (pr) model_init();
        else    model_tick(h1, h2);
    endtask

    // Finish the frame; the short hit pulse while refresh is low must never be seen
    task automatic settle();
        repeat (2) @(negedge clock);
        p1_hit = 1'b0;
        p2_hit = 1'b0;
        refresh = 1'b0;
        @(negedge clock);
        p1_hit = 1'b1;
        p2_hit = 1'b1;
        @(negedge clock);
        p1_hit = 1'b0;
        p2_hit = 1'b0;
    endtask

    typedef struct {
        logic h1, h2, pr;
        int   l1, l2, i1, i2, w;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic h1, input logic h2, input logic pr,
                                input int l1, input int l2, input int i1, input int i2,
                                input int w);
        vec_t v;
        v.h1 = h1; v.h2 = h2; v.pr = pr;
        v.l1 = l1; v.l2 = l2; v.i1 = i1; v.i2 = i2; v.w = w;
        tbl.push_back(v);
    endfunction

    initial begin
        // idle after reset
        for (int k = 0; k < 3; k++) add(0, 0, 0, 3, 3, 0, 0, 0);
        // p1 hit held for 10 ticks
        add(1, 0, 0, 2, 3, 1, 0, 0);
        for (int k = 0; k < 7; k++) add(1, 0, 0, 2, 3, 1, 0, 0);
        add(1, 0, 0, 1, 3, 1, 0, 0);
        add(1, 0, 0, 1, 3, 1, 0, 0);
        // both down to 1/1, then a simultaneous kill is a draw
        add(0, 0, 1, 3, 3, 0, 0, 0);
        add(1, 1, 0, 2, 2, 1, 1, 0);
        for (int k = 0; k < 7; k++) add(0, 0, 0, 2, 2, 1, 1, 0);
        add(0, 0, 0, 2, 2, 0, 0, 0);
        add(1, 1, 0, 1, 1, 1, 1, 0);
        for (int k = 0; k < 7; k++) add(0, 0, 0, 1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 3);
        add(1, 1, 0, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 3);
        // P2 dies with P1 on 2 lives, then P1 hits are frozen out
        add(0, 0, 1, 3, 3, 0, 0, 0);
        add(0, 1, 0, 3, 2, 0, 1, 0);
        for (int k = 0; k < 7; k++) add(0, 0, 0, 3, 2, 0, 1, 0);
        add(0, 0, 0, 3, 2, 0, 0, 0);
        add(1, 1, 0, 2, 1, 1, 1, 0);
        for (int k = 0; k < 7; k++) add(1, 1, 0, 2, 1, 1, 1, 0);
        add(0, 1, 0, 2, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) add(1, 0, 0, 2, 0, 0, 0, 1);
        // player_reset coincident with a tick carrying a hit
        add(0, 1, 1, 3, 3, 0, 0, 0);
        add(0, 0, 0, 3, 3, 0, 0, 0);

        // reset with refresh held high; a hit held across release must not register
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("in_reset p1_lives", int'(p1_lives), START);
        chk("in_reset winner", int'(winner), 0);
        chk("in_reset p1_invuln", int'(p1_invuln), 0);
        reset = 1'b0;
        p1_hit = 1'b1;
        model_init();
        @(negedge clock);
        chk("release p1_lives", int'(p1_lives), START);
        @(negedge clock);
        chk("release2 p1_lives", int'(p1_lives), START);
        chk("release2 winner", int'(winner), 0);
        p1_hit = 1'b0;
        refresh = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < tbl.size(); i++) begin
            run_tick(tbl[i].h1, tbl[i].h2, tbl[i].pr);
            chk($sformatf("row%0d p1_lives", i), int'(p1_lives), tbl[i].l1);
            chk($sformatf("row%0d p2_lives", i), int'(p2_lives), tbl[i].l2);
            chk($sformatf("row%0d p1_invuln", i), int'(p1_invuln), tbl[i].i1);
            chk($sformatf("row%0d p2_invuln", i), int'(p2_invuln), tbl[i].i2);
            chk($sformatf("row%0d winner", i), int'(winner), tbl[i].w);
            chk($sformatf("row%0d p1_blink", i), int'(p1_blink), exp_blink(0));
            $display("row %0d: hit=%0d/%0d prst=%0d lives=%0d/%0d inv=%0d/%0d win=%0d",
                     i, tbl[i].h1, tbl[i].h2, tbl[i].pr, p1_lives, p2_lives,
                     p1_invuln, p2_invuln, winner);
            settle();
        end

        // blink pattern across one cooldown window
        run_tick(0, 0, 1);
        settle();
        run_tick(1, 0, 0);
        chk("blink entry", int'(p1_blink), 0);
        settle();
        for (int j = 1; j <= CD; j++) begin
            int eb;
`ifdef LIVES_BLINK_EN
            eb = (j < CD) ? (j % 2) : 0;
`else
            eb = 0;
`endif
            run_tick(0, 0, 0);
            chk($sformatf("blink tick+%0d", j), int'(p1_blink), eb);
            $display("blink tick+%0d: p1_blink=%0d inv=%0d", j, p1_blink, p1_invuln);
            settle();
        end

        // asynchronous reset in the middle of a cooldown
        run_tick(1, 0, 0);
        settle();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async p1_lives", int'(p1_lives), START);
        chk("async p1_invuln", int'(p1_invuln), 0);
        @(negedge clock);
        reset = 1'b0;
        model_init();
        @(negedge clock);
        check_model("post_async");

        // random frames against the model
        for (int i = 0; i < 400; i++) begin
            logic h1, h2, pr;
            h1 = ($urandom_range(0, 2) == 0);
            h2 = ($urandom_range(0, 2) == 0);
            pr = ($urandom_range(0, 29) == 0);
            run_tick(h1, h2, pr);
            check_model($sformatf("rnd%0d", i));
            $display("rnd %0d: hit=%0d/%0d prst=%0d lives=%0d/%0d inv=%0d/%0d win=%0d",
                     i, h1, h2, pr, p1_lives, p2_lives, p1_invuln, p2_invuln, winner);
            settle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bomberman_lives.md
# bomberman_lives

Per-player health tracker for the two Bomberman players. It converts raw per-frame "player overlaps explosion" indications into registered life counts, post-hit invulnerability windows and a latched winner code. It sits directly upstream of the game control FSM, supplying the `p1_lives` and `p2_lives` inputs it uses for game-over detection and HP-icon drawing. It consumes that FSM's `refresh` frame tick and `player_reset` strobe.

## Interface
Parameters:
- `START_LIVES`, default 3: lives loaded on reset or `player_reset`. Legal range 1..3.
- `COOLDOWN_TICKS`, default 8: invulnerability length, in refresh ticks. Legal range 1..15.

Ports:
- `clock`, in, 1: system clock, 50 MHz.
- `reset`, in, 1: asynchronous, active-high; all state goes to reset values.
- `player_reset`, in, 1: synchronous re-initialise, same values as `reset`. Has priority over a tick.
- `refresh`, in, 1: frame-rate level from the control frame counter. High for many clocks per assertion.
- `p1_hit`, in, 1: player 1 overlaps an explosion tile. Level input, sampled only on a tick.
- `p2_hit`, in, 1: same as `p1_hit`, for player 2.
- `p1_lives`, out, 2: player 1 remaining lives.
- `p2_lives`, out, 2: player 2 remaining lives.
- `p1_invuln`, out, 1: high while player 1 is in INVULN.
- `p2_invuln`, out, 1: high while player 2 is in INVULN.
- `p1_blink`, out, 1: sprite-hide strobe for player 1 (see Configuration).
- `p2_blink`, out, 1: sprite-hide strobe for player 2 (see Configuration).
- `winner`, out, 2: 0 = game running, 1 = P1 wins, 2 = P2 wins, 3 = draw.

## Operation
- Tick detection:
  - `tick` = `refresh` AND NOT `refresh_q`, where `refresh_q` is a 1-clock delayed copy of `refresh`.
  - `refresh_q` resets to 1, so a `refresh` that is already high at reset release does not produce a tick.
- Each player has an identical FSM with states ALIVE, INVULN and DEAD, plus a 4-bit cooldown counter `cd`.
- ALIVE:
  - On a tick with hit=1, lives decrement by 1.
  - If the result is 0, go to DEAD. Otherwise go to INVULN with `cd` = COOLDOWN_TICKS-1.
- INVULN:
  - Hits are ignored.
  - On each tick, if `cd`==0 go to ALIVE; otherwise decrement `cd`.
- DEAD:
  - Lives hold at 0.
  - Only `reset` or `player_reset` exits this state.
- Freeze:
  - Once `winner` != 0, no further hits are processed for either player.
  - INVULN countdown continues while frozen.
- Winner is latched on the tick where one or both players reach 0 lives:
  - only P2 reaches 0 → 1;
  - only P1 reaches 0 → 2;
  - both reach 0 on the same tick → 3.
- Lives arithmetic is 2-bit unsigned and never wraps: a decrement is applied only from lives ≥ 1.
- Reset values: lives = START_LIVES, both FSMs ALIVE, `cd` = 0, `p*_invuln` = 0, `p*_blink` = 0, `winner` = 0.

## Timing
- All outputs are registered.
- A tick is asserted in the clock cycle where `refresh` rises.
- Lives, invuln, blink and winner reflect that tick's hit evaluation on the following clock edge (latency 1 clock from the `refresh` rise).
- A hit asserted and deasserted entirely between ticks is not seen.
- INVULN lasts exactly COOLDOWN_TICKS ticks: the player is vulnerable again on tick N+COOLDOWN_TICKS after being hit on tick N.
- `player_reset` and a tick in the same cycle: `player_reset` wins and the tick is discarded.
- `reset` asserted mid-cooldown or mid-game: outputs return to reset values asynchronously.

## Configuration
- `LIVES_BLINK_EN` defined:
  - `pN_blink` resets to 0 on entry to INVULN and toggles on every tick while in INVULN.
  - `pN_blink` is forced to 0 in ALIVE and DEAD.
- `LIVES_BLINK_EN` undefined:
  - `p1_blink` and `p2_blink` are tied to 0.
  - No blink registers are generated.
- All other behaviour is identical with and without the macro.

## Test plan
- Reset with `refresh` held high, release, no hits for 3 ticks → lives 3/3, `winner` 0, no tick on the first cycle after release.
- `p1_hit`=1 held across 10 ticks (COOLDOWN_TICKS=8):
  - `p1_lives` 3→2 one clock after tick 1;
  - `p1_invuln` high for ticks 1–8;
  - `p1_lives` 2→1 at tick 9.
- Both hit on the same tick with lives 1/1 → lives 0/0, `winner` 3 one clock after the tick; further ticks change nothing.
- P2 reaches 0 while P1 has 2 lives, then `p1_hit` held → `winner` 1, `p1_lives` stays 2 (freeze).
- `player_reset` pulsed in the same cycle as a tick with `p2_hit`=1 → lives 3/3, both ALIVE, `winner` 0.
- With `LIVES_BLINK_EN` defined, P1 hit:
  - `p1_blink` pattern 0,1,0,1,… on successive ticks during INVULN;
  - `p1_blink` is 0 after return to ALIVE.
  - Without the macro, `p1_blink` is constantly 0.
